// File: rtl/pointer_access_unit.sv
// Pointer access stage: label lookup, bounds check, one 32-bit memory access.
// Optional PACU_STAT_EN builds saturating access/fault counters.
module pointer_access_unit #(
   parameter int IDX_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [11:0]       req_lbid,
   input  logic [15:0]       req_ofs,
   input  logic [15:0]       req_disp,
   input  logic [31:0]       req_wdata,
   input  logic              lt_we,
   input  logic [IDX_W-1:0]  lt_idx,
   input  logic [31:0]       lt_base,
   input  logic [15:0]       lt_size,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic [1:0]        rsp_fault,
   output logic [15:0]       stat_access,
   output logic [15:0]       stat_fault
);

   localparam int DEPTH = 1 << IDX_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_MREQ,
      S_MWAIT,
      S_RESP
   } state_t;

   state_t state, state_nx;

   logic              we_q;
   logic [11:0]       lbid_q;
   logic [15:0]       ofs_q;
   logic [15:0]       disp_q;
   logic [31:0]       wdata_q;

   logic [31:0]       tbl_base [DEPTH];
   logic [15:0]       tbl_size [DEPTH];
   logic [DEPTH-1:0]  tbl_vld;

   logic [IDX_W-1:0]  idx;
   logic [17:0]       eff;
   logic              bad_lbl;
   logic              oob;
   logic [1:0]        code;

   // Effective offset and fault classification from the latched request
   always_comb begin
      idx     = lbid_q[IDX_W-1:0];
      eff     = {2'b00, ofs_q} + {{2{disp_q[15]}}, disp_q};
      bad_lbl = (lbid_q[11:IDX_W] != '0) || !tbl_vld[idx];
      oob     = eff[17] || (eff[16:0] >= {1'b0, tbl_size[idx]});
      if (bad_lbl) begin
         code = 2'b01;
      end else if (oob) begin
         code = 2'b10;
      end else begin
         code = 2'b00;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (req_valid) begin
               state_nx = S_CALC;
            end
         end
         S_CALC: begin
            state_nx = (code != 2'b00) ? S_RESP : S_MREQ;
         end
         S_MREQ: begin
            if (mem_ready) begin
               state_nx = we_q ? S_RESP : S_MWAIT;
            end
         end
         S_MWAIT: begin
            if (mem_rvalid) begin
               state_nx = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign req_ready = (state == S_IDLE);
   assign mem_valid = (state == S_MREQ);
   assign rsp_valid = (state == S_RESP);

   // Label table; writes land at the edge so CALC sees pre-write contents
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tbl_vld <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tbl_base[i] <= '0;
            tbl_size[i] <= '0;
         end
      end else if (lt_we) begin
         tbl_vld[lt_idx]  <= 1'b1;
         tbl_base[lt_idx] <= lt_base;
         tbl_size[lt_idx] <= lt_size;
      end
   end

   // Request latch, memory request fields and response registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q      <= 1'b0;
         lbid_q    <= '0;
         ofs_q     <= '0;
         disp_q    <= '0;
         wdata_q   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_data  <= '0;
         rsp_fault <= '0;
      end else begin
         if (state == S_IDLE && req_valid) begin
            we_q    <= req_we;
            lbid_q  <= req_lbid;
            ofs_q   <= req_ofs;
            disp_q  <= req_disp;
            wdata_q <= req_wdata;
         end
         if (state == S_CALC) begin
            mem_addr  <= tbl_base[idx] + {16'h0000, eff[15:0]};
            mem_we    <= we_q;
            mem_wdata <= we_q ? wdata_q : 32'h0;
            rsp_fault <= code;
            rsp_data  <= 32'h0;
         end
         if (state == S_MWAIT && mem_rvalid) begin
            rsp_data <= mem_rdata;
         end
      end
   end

`ifdef PACU_STAT_EN
   logic [15:0] acc_q;
   logic [15:0] flt_q;

   // Count each response once, at its handshake, saturating at all-ones
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         flt_q <= '0;
      end else if (state == S_RESP && rsp_ready) begin
         if (rsp_fault == 2'b00) begin
            if (acc_q != 16'hFFFF) begin
               acc_q <= acc_q + 16'd1;
            end
         end else begin
            if (flt_q != 16'hFFFF) begin
               flt_q <= flt_q + 16'd1;
            end
         end
      end
   end

   assign stat_access = acc_q;
   assign stat_fault  = flt_q;
`else
   assign stat_access = 16'h0000;
   assign stat_fault  = 16'h0000;
`endif

endmodule
